// File: rtl/register_writeback_if.sv
// Writeback-side bundle between execute, read stage and the register file owner.
// Carries commit requests, scoreboard reservations and source checks.
interface register_writeback_if;
  logic        wbValidIn;
  logic        wbReadyOut;
  logic [3:0]  destRegIn;
  logic        destRegValidIn;
  logic [63:0] destValIn;
  logic [3:0]  destRegSpecialIn;
  logic        destRegSpecialValidIn;
  logic [63:0] destValSpecialIn;
  logic        reserveValidIn;
  logic [3:0]  reserveRegIn;
  logic        reserveSpecialValidIn;
  logic [3:0]  reserveSpecialRegIn;
  logic [3:0]  checkReg1In;
  logic [3:0]  checkReg2In;
  logic        checkReg1ValidIn;
  logic        checkReg2ValidIn;
  logic [63:0] registerFileOut [16];
  logic        wbStallOut;
  logic [31:0] commitCountOut;

  modport master (
    output wbValidIn, destRegIn, destRegValidIn, destValIn,
           destRegSpecialIn, destRegSpecialValidIn, destValSpecialIn,
           reserveValidIn, reserveRegIn, reserveSpecialValidIn, reserveSpecialRegIn,
           checkReg1In, checkReg2In, checkReg1ValidIn, checkReg2ValidIn,
    input  wbReadyOut, registerFileOut, wbStallOut, commitCountOut
  );

  modport slave (
    input  wbValidIn, destRegIn, destRegValidIn, destValIn,
           destRegSpecialIn, destRegSpecialValidIn, destValSpecialIn,
           reserveValidIn, reserveRegIn, reserveSpecialValidIn, reserveSpecialRegIn,
           checkReg1In, checkReg2In, checkReg1ValidIn, checkReg2ValidIn,
    output wbReadyOut, registerFileOut, wbStallOut, commitCountOut
  );
endinterface

// File: rtl/register_writeback.sv
// Architectural register file with writeback commit (incl. dual RDX:RAX destination)
// and a per-register pending-write scoreboard that stalls the read stage.
module register_writeback #(
  parameter logic [63:0] RESET_RSP = 64'h0,
  parameter int          PEND_W    = 2
) (
  input logic            clk,
  input logic            reset,
  register_writeback_if.slave bus
);

  typedef enum logic {IDLE, SECOND} state_e;

  localparam logic [PEND_W-1:0] PEND_MAX = '1;
  localparam logic [PEND_W-1:0] PEND_ONE = {{(PEND_W-1){1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic [63:0]       regFile_q [16];
  logic [PEND_W-1:0] pend_q [16];
  logic [PEND_W-1:0] pend_d [16];
  logic [3:0]        specReg_q, specReg_d;
  logic [63:0]       specVal_q, specVal_d;
  logic [31:0]       commitCount_q;

  logic              accept;
  logic              wrEn;
  logic [3:0]        wrReg;
  logic [63:0]       wrVal;

  // At most one register write per cycle: a dual distinct commit is split over IDLE and SECOND.
  always_comb begin
    state_d        = state_q;
    specReg_d      = specReg_q;
    specVal_d      = specVal_q;
    wrEn           = 1'b0;
    wrReg          = 4'd0;
    wrVal          = 64'd0;
    accept         = 1'b0;
    bus.wbReadyOut = 1'b0;
    case (state_q)
      IDLE: begin
        bus.wbReadyOut = 1'b1;
        accept         = bus.wbValidIn;
        if (accept) begin
          if (bus.destRegSpecialValidIn &&
              (!bus.destRegValidIn || bus.destRegIn == bus.destRegSpecialIn)) begin
            wrEn  = 1'b1;
            wrReg = bus.destRegSpecialIn;
            wrVal = bus.destValSpecialIn;
          end else if (bus.destRegValidIn) begin
            wrEn  = 1'b1;
            wrReg = bus.destRegIn;
            wrVal = bus.destValIn;
            if (bus.destRegSpecialValidIn) begin
              specReg_d = bus.destRegSpecialIn;
              specVal_d = bus.destValSpecialIn;
              state_d   = SECOND;
            end
          end
        end
      end
      SECOND: begin
        wrEn    = 1'b1;
        wrReg   = specReg_q;
        wrVal   = specVal_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A reserve into a saturated counter is dropped and stalls the read stage instead.
  always_comb begin
    logic resv;
    logic full;
    logic commit;
    logic inc;
    bus.wbStallOut = 1'b0;
    for (int r = 0; r < 16; r++) begin
      resv   = (bus.reserveValidIn && bus.reserveRegIn == 4'(r)) ||
               (bus.reserveSpecialValidIn && bus.reserveSpecialRegIn == 4'(r));
      full   = (pend_q[r] == PEND_MAX);
      commit = wrEn && (wrReg == 4'(r));
      inc    = resv && !full;
      pend_d[r] = pend_q[r];
      if (resv && full) begin
        bus.wbStallOut = 1'b1;
      end
      if (inc && !commit) begin
        pend_d[r] = pend_q[r] + PEND_ONE;
      end else if (!inc && commit && pend_q[r] != '0) begin
        pend_d[r] = pend_q[r] - PEND_ONE;
      end
    end
    if (bus.checkReg1ValidIn && pend_q[bus.checkReg1In] != '0) begin
      bus.wbStallOut = 1'b1;
    end
    if (bus.checkReg2ValidIn && pend_q[bus.checkReg2In] != '0) begin
      bus.wbStallOut = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      specReg_q     <= 4'd0;
      specVal_q     <= 64'd0;
      commitCount_q <= 32'd0;
      for (int i = 0; i < 16; i++) begin
        pend_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      specReg_q <= specReg_d;
      specVal_q <= specVal_d;
      if (accept) begin
        commitCount_q <= commitCount_q + 32'd1;
      end
      for (int i = 0; i < 16; i++) begin
        pend_q[i] <= pend_d[i];
      end
    end
  end

  // R4 is the stack pointer and comes out of reset at RESET_RSP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) begin
        regFile_q[i] <= (i == 4) ? RESET_RSP : 64'd0;
      end
    end else if (wrEn) begin
      regFile_q[wrReg] <= wrVal;
    end
  end

  assign bus.registerFileOut = regFile_q;
  assign bus.commitCountOut  = commitCount_q;

endmodule
